// File: rtl/daq_event_pager.sv
// daq_event_pager: framed event stream stored one event per RAM page, read oldest-first.
// Optional DAQ_EVENT_PAGER_HEADER_EN prepends a commit-time header word to each page.
module daq_event_pager #(
    parameter int DATA_W       = 32,
    parameter int PAGE_AW      = 9,
    parameter int NPAGE_AW     = 4,
    parameter int BACKPRESSURE = 0,
    parameter int DROP_W       = 16
) (
    input  logic                axi_clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic [PAGE_AW-1:0]  rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [PAGE_AW:0]    rd_len,
    output logic                rd_trunc,
    input  logic                advance,
    output logic [NPAGE_AW:0]   occupancy,
    output logic                empty,
    output logic                full,
    output logic [DROP_W-1:0]   drop_count
);

    localparam int NUM_PAGES = 2 ** NPAGE_AW;
    localparam int AW        = NPAGE_AW + PAGE_AW;
    localparam logic [PAGE_AW:0]  WPTR_MAX = {1'b1, {PAGE_AW{1'b0}}};
    localparam logic [NPAGE_AW:0] OCC_MAX  = {1'b1, {NPAGE_AW{1'b0}}};
`ifdef DAQ_EVENT_PAGER_HEADER_EN
    localparam bit                 HDR_EN = 1'b1;
    localparam logic [PAGE_AW-1:0] FIRST  = PAGE_AW'(1);
`else
    localparam bit                 HDR_EN = 1'b0;
    localparam logic [PAGE_AW-1:0] FIRST  = '0;
`endif

    typedef enum logic [2:0] {IDLE, WRITE, DROP, FLUSH, HDR} state_e;

    state_e                state_q, state_d;
    logic [NPAGE_AW-1:0]   w_page_q, w_page_d;
    logic [NPAGE_AW-1:0]   r_page_q, r_page_d;
    logic [NPAGE_AW:0]     occ_q, occ_d;
    logic [PAGE_AW:0]      wptr_q, wptr_d;
    logic                  trunc_q, trunc_d;
    logic [DROP_W-1:0]     drops_q, drops_d, drops_inc;
    logic [PAGE_AW:0]      len_q [NUM_PAGES];
    logic                  tflag_q [NUM_PAGES];
    logic [DATA_W-1:0]     rd_data_q;
    logic [PAGE_AW:0]      rd_len_q;
    logic                  rd_trunc_q;
    logic [DATA_W-1:0]     mem [2**AW];
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     hdr_word;
    logic                  commit;
    logic                  accept;
    logic                  adv_ok;

    assign full       = (occ_q == OCC_MAX);
    assign empty      = (occ_q == '0);
    assign occupancy  = occ_q;
    assign drop_count = drops_q;
    assign rd_data    = rd_data_q;
    assign rd_len     = rd_len_q;
    assign rd_trunc   = rd_trunc_q;
    assign accept     = in_valid && in_ready;
    assign adv_ok     = advance && !empty;
    assign drops_inc  = (&drops_q) ? drops_q : drops_q + 1'b1;

    // Stalling is only ever done between events, never inside one.
    assign in_ready = !(state_q == HDR ||
                        (BACKPRESSURE != 0 && state_q == IDLE && full));

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        trunc_d = trunc_q;
        drops_d = drops_q;
        we      = 1'b0;
        waddr   = {w_page_q, wptr_q[PAGE_AW-1:0]};
        wdata   = in_data;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && !full) begin
                    we      = 1'b1;
                    waddr   = {w_page_q, FIRST};
                    wptr_d  = {1'b0, FIRST} + 1'b1;
                    trunc_d = 1'b0;
                    if (!in_last)    state_d = WRITE;
                    else if (HDR_EN) state_d = HDR;
                    else             commit  = 1'b1;
                end else if (accept) begin
                    if (in_last) drops_d = drops_inc;
                    else         state_d = DROP;
                end
            end
            WRITE: begin
                if (accept) begin
                    if (wptr_q != WPTR_MAX) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = HDR_EN ? HDR : IDLE;
                        commit  = !HDR_EN;
                    end
                end
            end
            DROP: begin
                if (accept && in_last) begin
                    drops_d = drops_inc;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (accept && in_last) state_d = IDLE;
            end
            HDR: begin
                we      = 1'b1;
                waddr   = {w_page_q, {PAGE_AW{1'b0}}};
                wdata   = hdr_word;
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A partial event at clear time is swallowed without being counted.
        if (clear) begin
            state_d = (state_q == WRITE || state_q == DROP ||
                       state_q == FLUSH) ? FLUSH : IDLE;
            wptr_d  = '0;
            trunc_d = 1'b0;
            drops_d = '0;
            we      = 1'b0;
            commit  = 1'b0;
        end
    end

    always_comb begin
        w_page_d = w_page_q + NPAGE_AW'(commit);
        r_page_d = r_page_q + NPAGE_AW'(adv_ok);
        occ_d    = occ_q;
        if (commit && !adv_ok)      occ_d = occ_q + 1'b1;
        else if (!commit && adv_ok) occ_d = occ_q - 1'b1;
        if (clear) begin
            w_page_d = '0;
            r_page_d = '0;
            occ_d    = '0;
        end
    end

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            w_page_q <= '0;
            r_page_q <= '0;
            occ_q    <= '0;
            wptr_q   <= '0;
            trunc_q  <= 1'b0;
            drops_q  <= '0;
        end else begin
            state_q  <= state_d;
            w_page_q <= w_page_d;
            r_page_q <= r_page_d;
            occ_q    <= occ_d;
            wptr_q   <= wptr_d;
            trunc_q  <= trunc_d;
            drops_q  <= drops_d;
        end
    end

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PAGES; i++) begin
                len_q[i]   <= '0;
                tflag_q[i] <= 1'b0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_PAGES; i++) begin
                len_q[i]   <= '0;
                tflag_q[i] <= 1'b0;
            end
        end else if (commit) begin
            len_q[w_page_q]   <= wptr_d;
            tflag_q[w_page_q] <= trunc_d;
        end
    end

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_len_q   <= '0;
            rd_trunc_q <= 1'b0;
        end else if (clear) begin
            rd_len_q   <= '0;
            rd_trunc_q <= 1'b0;
        end else begin
            rd_len_q   <= len_q[r_page_q];
            rd_trunc_q <= tflag_q[r_page_q];
        end
    end

    // Read register survives clear so software can still see the last word.
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) rd_data_q <= '0;
        else          rd_data_q <= mem[{r_page_q, rd_addr}];
    end

    always_ff @(posedge axi_clk) begin
        if (we) mem[waddr] <= wdata;
    end

`ifdef DAQ_EVENT_PAGER_HEADER_EN
    logic [15:0] seq_q;
    logic [31:0] hdr;

    always_comb begin
        hdr            = '0;
        hdr[31:16]     = seq_q;
        hdr[15]        = trunc_q;
        hdr[PAGE_AW:0] = wptr_q - 1'b1;
    end

    assign hdr_word = DATA_W'(hdr);

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n)    seq_q <= '0;
        else if (clear)  seq_q <= '0;
        else if (commit) seq_q <= seq_q + 1'b1;
    end
`else
    assign hdr_word = '0;
`endif

endmodule

// File: tb/tb_daq_event_pager.sv
// Directed bench for daq_event_pager: 16-word pages, 4 pages, drop and stall variants.
module tb_daq_event_pager;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] din = '0;
    logic        vld = 1'b0;
    logic        lst = 1'b0;
    logic        adv = 1'b0;
    logic [3:0]  raddr = '0;
    logic        sel = 1'b0;

    logic        rdy0, rtr0, emp0, ful0;
    logic [31:0] rdata0;
    logic [4:0]  rlen0;
    logic [2:0]  occ0;
    logic [15:0] drp0;
    logic        rdy1, rtr1, emp1, ful1;
    logic [31:0] rdata1;
    logic [4:0]  rlen1;
    logic [2:0]  occ1;
    logic [15:0] drp1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    daq_event_pager #(
        .DATA_W(32), .PAGE_AW(4), .NPAGE_AW(2), .BACKPRESSURE(0), .DROP_W(16)
    ) u_drop (
        .axi_clk(clk), .reset_n(rst_n), .clear(clr),
        .in_data(din), .in_valid(vld), .in_last(lst), .in_ready(rdy0),
        .rd_addr(raddr), .rd_data(rdata0), .rd_len(rlen0), .rd_trunc(rtr0),
        .advance(adv), .occupancy(occ0), .empty(emp0), .full(ful0),
        .drop_count(drp0)
    );

    daq_event_pager #(
        .DATA_W(32), .PAGE_AW(4), .NPAGE_AW(2), .BACKPRESSURE(1), .DROP_W(16)
    ) u_stall (
        .axi_clk(clk), .reset_n(rst_n), .clear(clr),
        .in_data(din), .in_valid(vld), .in_last(lst), .in_ready(rdy1),
        .rd_addr(raddr), .rd_data(rdata1), .rd_len(rlen1), .rd_trunc(rtr1),
        .advance(adv), .occupancy(occ1), .empty(emp1), .full(ful1),
        .drop_count(drp1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy();
        return sel ? rdy1 : rdy0;
    endfunction

    task automatic do_reset();
        vld = 1'b0; lst = 1'b0; adv = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d, input logic last, input logic a);
        int n;
        n = 0;
        din = d; vld = 1'b1; lst = last; adv = a;
        while (!rdy() && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) chk("rdy_wait", rdy(), 1'b1);
        @(negedge clk);
        vld = 1'b0; lst = 1'b0; adv = 1'b0;
    endtask

    task automatic push_ev(input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++)
            push(base + i, (i == len - 1), 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        raddr = a;
        @(negedge clk);
    endtask

    task automatic pulse_adv();
        adv = 1'b1;
        @(negedge clk);
        adv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0;
        do_reset();
        chk("rst_occ", occ0, 0);
        chk("rst_empty", emp0, 1);
        chk("rst_full", ful0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_rdata", rdata0, 0);
        chk("rst_rlen", rlen0, 0);
        chk("rst_drops", drp0, 0);

        // event A0..A2, read word 1, release
        push_ev(32'hA000_0000, 3);
        chk("s1_occ", occ0, 1);
        rd(4'd1);
        chk("s1_rlen", rlen0, 3);
        chk("s1_rdata", rdata0, 32'hA000_0001);
        chk("s1_trunc", rtr0, 0);
        pulse_adv();
        chk("s1_empty", emp0, 1);
        chk("s1_occ0", occ0, 0);

        // fill, drop one event, wrap into page 0
        do_reset();
        for (int k = 0; k < 4; k++) push_ev(32'hB000_0000 + k * 16, 2);
        chk("s2_full", ful0, 1);
        push_ev(32'hB000_0040, 3);
        chk("s2_drops", drp0, 1);
        chk("s2_occ4", occ0, 4);
        pulse_adv();
        chk("s2_occ3", occ0, 3);
        push_ev(32'hB000_0050, 2);
        chk("s2_occ_wrap", occ0, 4);
        rd(4'd0);
        chk("s2_old_data", rdata0, 32'hB000_0010);
        chk("s2_old_len", rlen0, 2);
        repeat (3) pulse_adv();
        chk("s2_occ1", occ0, 1);
        rd(4'd1);
        chk("s2_wrap_data", rdata0, 32'hB000_0051);
        chk("s2_wrap_len", rlen0, 2);

        // oversize event truncated at 16 words
        do_reset();
        push_ev(32'hC000_0000, 20);
        rd(4'd15);
        chk("s3_rlen", rlen0, 16);
        chk("s3_trunc", rtr0, 1);
        chk("s3_word15", rdata0, 32'hC000_000F);
        push_ev(32'hC100_0000, 2);
        pulse_adv();
        rd(4'd0);
        chk("s3_next_data", rdata0, 32'hC100_0000);
        chk("s3_next_len", rlen0, 2);
        chk("s3_next_trunc", rtr0, 0);

        // commit and advance in the same cycle
        do_reset();
        push_ev(32'hD000_0000, 2);
        push_ev(32'hD100_0000, 3);
        push(32'hD200_0000, 1'b0, 1'b0);
        push(32'hD200_0001, 1'b1, 1'b1);
        chk("s4_occ", occ0, 2);
        rd(4'd0);
        chk("s4_rpage1_len", rlen0, 3);
        chk("s4_rpage1_data", rdata0, 32'hD100_0000);
        pulse_adv();
        rd(4'd1);
        chk("s4_p2_len", rlen0, 2);
        chk("s4_p2_data", rdata0, 32'hD200_0001);
        push(32'hD300_0000, 1'b1, 1'b0);
        chk("s4_occ_after", occ0, 2);
        pulse_adv();
        rd(4'd0);
        chk("s4_p3_data", rdata0, 32'hD300_0000);
        chk("s4_p3_len", rlen0, 1);

        // backpressure variant stalls while full
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) push(32'hE000_0000 + k, 1'b1, 1'b0);
        chk("s5_full", ful1, 1);
        din = 32'hE0FF_0000; vld = 1'b1; lst = 1'b1;
        chk("s5_stall", rdy1, 0);
        repeat (2) @(negedge clk);
        chk("s5_hold_occ", occ1, 4);
        chk("s5_hold_drops", drp1, 0);
        adv = 1'b1;
        @(negedge clk);
        adv = 1'b0;
        chk("s5_ready_up", rdy1, 1);
        chk("s5_occ3", occ1, 3);
        @(negedge clk);
        vld = 1'b0; lst = 1'b0;
        chk("s5_occ4", occ1, 4);
        chk("s5_drops", drp1, 0);
        rd(4'd0);
        chk("s5_p1_data", rdata1, 32'hE000_0001);
        repeat (3) pulse_adv();
        rd(4'd0);
        chk("s5_wrap_data", rdata1, 32'hE0FF_0000);
        chk("s5_wrap_len", rlen1, 1);
        sel = 1'b0;

        // clear mid-event, then async reset
        do_reset();
        push(32'hF000_0000, 1'b0, 1'b0);
        push(32'hF000_0001, 1'b0, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("s6_clr_occ", occ0, 0);
        push_ev(32'hF100_0000, 3);
        chk("s6_flush_occ", occ0, 0);
        push(32'hF200_00BB, 1'b1, 1'b0);
        chk("s6_occ", occ0, 1);
        chk("s6_drops", drp0, 0);
        rd(4'd0);
        chk("s6_rlen", rlen0, 1);
        chk("s6_rdata", rdata0, 32'hF200_00BB);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("s6_clr2_empty", emp0, 1);
        chk("s6_clr2_rlen", rlen0, 0);
        chk("s6_clr2_rdata", rdata0, 32'hF200_00BB);
        push(32'hF300_0000, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_arst_occ", occ0, 0);
        chk("s6_arst_empty", emp0, 1);
        chk("s6_arst_full", ful0, 0);
        chk("s6_arst_ready", rdy0, 1);
        chk("s6_arst_rdata", rdata0, 0);
        chk("s6_arst_rlen", rlen0, 0);
        chk("s6_arst_trunc", rtr0, 0);
        chk("s6_arst_drops", drp0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
